alarm_tone_gen: RTL and testbench

ALARM_TONE_GEN -- requirements
Module: alarm_tone_gen

---
 rtl/alarm_sound_pkg.sv | 20 ++
 rtl/tone_divider.sv | 40 ++++
 rtl/alarm_tone_gen.sv | 141 ++++++++++++++
 tb/tb_alarm_tone_gen.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_sound_pkg.sv
// Shared types and melody constants for the alarm tone generator.
// Half-periods are expressed in clk cycles.
package alarm_sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2,
    ST_MUTE = 2'd3
  } state_e;

  localparam int MELODY_LEN = 8;
  localparam int NOTE_W     = 16;

  // A zero entry is a rest: the step keeps its timing but stays silent.
  localparam logic [NOTE_W-1:0] HALF_PERIOD [MELODY_LEN] = '{
    16'd2, 16'd3, 16'd1, 16'd4, 16'd0, 16'd2, 16'd5, 16'd3
  };

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles wave every half_period clk cycles after restart.
// A half_period of zero holds the wave low.
module tone_divider (
  input  logic        clk,
  input  logic        rstn,
  input  logic        restart,
  input  logic [15:0] half_period,
  output logic        wave
);

  logic [15:0] cnt_q, cnt_d;
  logic        wave_q, wave_d;

  always_comb begin
    cnt_d  = cnt_q;
    wave_d = wave_q;
    if (restart || (half_period == 16'd0)) begin
      cnt_d  = 16'd0;
      wave_d = 1'b0;
    end else if (cnt_q == (half_period - 16'd1)) begin
      cnt_d  = 16'd0;
      wave_d = ~wave_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= 16'd0;
      wave_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wave_q <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/alarm_tone_gen.sv
// Alarm melody sequencer: steps through the melody table while aud_en is high,
// with a silent gap after each step and a user mute that lasts until aud_en drops.
module alarm_tone_gen
  import alarm_sound_pkg::*;
#(
  parameter int CLK_DIV    = 10000,
  parameter int NOTE_TICKS = 20,
  parameter int GAP_TICKS  = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       aud_en,
  input  logic       ack,
  output logic       spk,
  output logic       playing,
  output logic [2:0] note_idx
);

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [7:0]  NOTE_LAST = 8'(NOTE_TICKS - 1);
  localparam logic [7:0]  GAP_LAST  = 8'((GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0);
  localparam bit          HAS_GAP   = (GAP_TICKS > 0);

  state_e      state_q, state_d;
  logic [2:0]  note_idx_q, note_idx_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  tick_cnt_q, tick_cnt_d;
  logic        playing_q, playing_d;
  logic        tick;
  logic        step_start;
  logic        restart;
  logic        wave;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    note_idx_d = note_idx_q;
    div_d      = div_q;
    tick_cnt_d = tick_cnt_q;
    step_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aud_en) begin
          state_d    = ST_PLAY;
          note_idx_d = 3'd0;
          step_start = 1'b1;
        end
      end
      ST_PLAY: begin
        if (!aud_en) begin
          state_d    = ST_IDLE;
          note_idx_d = 3'd0;
        end else if (ack) begin
          state_d = ST_MUTE;
        end else begin
          div_d = tick ? 16'd0 : div_q + 16'd1;
          if (tick) begin
            if (tick_cnt_q == NOTE_LAST) begin
              if (HAS_GAP) begin
                state_d = ST_GAP;
              end else begin
                note_idx_d = note_idx_q + 3'd1;
                step_start = 1'b1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end
        end
      end
      ST_GAP: begin
        if (!aud_en) begin
          state_d    = ST_IDLE;
          note_idx_d = 3'd0;
        end else if (ack) begin
          state_d = ST_MUTE;
        end else begin
          div_d = tick ? 16'd0 : div_q + 16'd1;
          if (tick) begin
            if (tick_cnt_q == GAP_LAST) begin
              state_d    = ST_PLAY;
              note_idx_d = note_idx_q + 3'd1;
              step_start = 1'b1;
            end else begin
              tick_cnt_d = tick_cnt_q + 8'd1;
            end
          end
        end
      end
      ST_MUTE: begin
        if (!aud_en) begin
          state_d    = ST_IDLE;
          note_idx_d = 3'd0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        note_idx_d = 3'd0;
      end
    endcase
    // Every state entry and every new step restarts tick timing from zero.
    if ((state_d != state_q) || step_start) begin
      div_d      = 16'd0;
      tick_cnt_d = 8'd0;
    end
    playing_d = (state_d == ST_PLAY) || (state_d == ST_GAP);
  end

  // Holding the divider in restart outside PLAY is what silences spk in GAP/IDLE/MUTE.
  assign restart = (state_d != ST_PLAY) || step_start;

  tone_divider u_tone_divider (
    .clk         (clk),
    .rstn        (rstn),
    .restart     (restart),
    .half_period (HALF_PERIOD[note_idx_q]),
    .wave        (wave)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      note_idx_q <= 3'd0;
      div_q      <= 16'd0;
      tick_cnt_q <= 8'd0;
      playing_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      note_idx_q <= note_idx_d;
      div_q      <= div_d;
      tick_cnt_q <= tick_cnt_d;
      playing_q  <= playing_d;
    end
  end

  assign spk      = wave;
  assign playing  = playing_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Directed bench for alarm_tone_gen: a gapped build and a gapless build run side by side
// against a step-timing reference model, with expected outputs queued per clock.
module tb_alarm_tone_gen;
  import alarm_sound_pkg::*;

  localparam int CLK_DIV    = 4;
  localparam int NOTE_TICKS = 2;
  localparam int GAP_TICKS  = 1;
  localparam int NOTE_LEN   = CLK_DIV * NOTE_TICKS;
  localparam int GAP_LEN_A  = CLK_DIV * GAP_TICKS;

  logic       clk = 1'b0;
  logic       rstn;
  logic       aud_en;
  logic       ack;
  logic       spk_a, playing_a, spk_b, playing_b;
  logic [2:0] note_idx_a, note_idx_b;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alarm_tone_gen #(.CLK_DIV(CLK_DIV), .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(GAP_TICKS)) dut_a (
    .clk(clk), .rstn(rstn), .aud_en(aud_en), .ack(ack),
    .spk(spk_a), .playing(playing_a), .note_idx(note_idx_a)
  );

  alarm_tone_gen #(.CLK_DIV(CLK_DIV), .NOTE_TICKS(NOTE_TICKS), .GAP_TICKS(0)) dut_b (
    .clk(clk), .rstn(rstn), .aud_en(aud_en), .ack(ack),
    .spk(spk_b), .playing(playing_b), .note_idx(note_idx_b)
  );

  // Reference: st 0=idle 1=play 2=gap 3=mute; cyc = clocks since the current phase began.
  typedef struct packed {
    logic [1:0]  st;
    logic [2:0]  idx;
    logic [15:0] cyc;
  } m_t;

  function automatic m_t mstep(m_t m, logic en, logic ak, int note_len, int gap_len);
    m_t n = m;
    if (m.st != 2'd0 && !en) begin
      n = '0;
    end else begin
      case (m.st)
        2'd0: if (en) n = '{st: 2'd1, idx: 3'd0, cyc: 16'd0};
        2'd1: begin
          if (ak) begin
            n.st = 2'd3; n.cyc = 16'd0;
          end else if (int'(m.cyc) + 1 == note_len) begin
            n.cyc = 16'd0;
            if (gap_len > 0) n.st = 2'd2;
            else n.idx = 3'((int'(m.idx) + 1) % 8);
          end else begin
            n.cyc = m.cyc + 16'd1;
          end
        end
        2'd2: begin
          if (ak) begin
            n.st = 2'd3; n.cyc = 16'd0;
          end else if (int'(m.cyc) + 1 == gap_len) begin
            n.st = 2'd1; n.cyc = 16'd0; n.idx = 3'((int'(m.idx) + 1) % 8);
          end else begin
            n.cyc = m.cyc + 16'd1;
          end
        end
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [4:0] mout(m_t m);
    int  hp = int'(HALF_PERIOD[m.idx]);
    logic s = (m.st == 2'd1) && (hp != 0) && (((int'(m.cyc) / (hp == 0 ? 1 : hp)) % 2) == 1);
    logic p = (m.st == 2'd1) || (m.st == 2'd2);
    return {s, p, m.idx};
  endfunction

  m_t ma = '0, mb = '0;
  logic [4:0] exp_qa[$];
  logic [4:0] exp_qb[$];

  always @(posedge clk) begin
    if (!rstn) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = mstep(ma, aud_en, ack, NOTE_LEN, GAP_LEN_A);
      mb = mstep(mb, aud_en, ack, NOTE_LEN, 0);
    end
    exp_qa.push_back(mout(ma));
    exp_qb.push_back(mout(mb));
  end

  task automatic check(string tag, logic [4:0] got, logic [4:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed {spk,playing,idx}=%b required %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(int n);
    logic [4:0] ea, eb;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (exp_qa.size() == 0 || exp_qb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL scoreboard: observed empty queue required an entry at %0t", $time);
      end else begin
        ea = exp_qa.pop_front();
        eb = exp_qb.pop_front();
        check("gap_build", {spk_a, playing_a, note_idx_a}, ea);
        check("nogap_build", {spk_b, playing_b, note_idx_b}, eb);
      end
    end
  endtask

  initial begin
    rstn   = 1'b0;
    aud_en = 1'b0;
    ack    = 1'b0;
    #1;
    check("reset_async_a", {spk_a, playing_a, note_idx_a}, 5'b0);
    check("reset_async_b", {spk_b, playing_b, note_idx_b}, 5'b0);
    step(2);
    rstn = 1'b1;
    step(2);
    // ack while idle does nothing
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    step(2);
    // full melody with wrap, including the rest step
    aud_en = 1'b1;
    step(1);
    check("playing_one_edge", {1'b0, playing_a, note_idx_a}, 5'b01000);
    step(12 * 8 + 14);
    // restart, then mute during step 3
    aud_en = 1'b0;
    step(2);
    aud_en = 1'b1;
    step(12 * 3 + 4);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("mute_silent", {spk_a, playing_a}, 2'b00);
    step(20);
    aud_en = 1'b0;
    step(2);
    aud_en = 1'b1;
    step(1);
    check("restart_after_mute", {playing_a, note_idx_a}, 4'b1000);
    // drop aud_en in the middle of step 5
    step(12 * 5 + 2);
    aud_en = 1'b0;
    step(2);
    // ack and aud_en falling together
    aud_en = 1'b1;
    step(12 * 2 + 2);
    ack    = 1'b1;
    aud_en = 1'b0;
    step(1);
    ack = 1'b0;
    step(2);
    // asynchronous reset inside a gap
    aud_en = 1'b1;
    step(12 + 9);
    check("in_gap_before_reset", {spk_a, playing_a, note_idx_a}, 5'b01001);
    #2 rstn = 1'b0;
    #1;
    check("reset_mid_gap", {spk_a, playing_a, note_idx_a}, 5'b0);
    step(2);
    rstn = 1'b1;
    step(1);
    check("restart_after_reset", {playing_a, note_idx_a}, 4'b1000);
    step(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
